// File: rtl/bus_memtest_initiator_pkg.sv
// Shared state encoding and LFSR polynomial for the bus memory-test initiator.
package memtest_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_W_REQ = 3'd1;
  localparam state_t ST_W_GAP = 3'd2;
  localparam state_t ST_R_GAP = 3'd3;
  localparam state_t ST_R_REQ = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] value);
    logic [31:0] shifted;
    shifted = {1'b0, value[31:1]};
    if (value[0]) begin
      lfsr_next = shifted ^ LFSR_MASK;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/bus_memtest_initiator_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (priority) and single-step advance.
module lfsr32
  import memtest_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0001
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_value
);

  logic [31:0] value_r;

  // State register: load wins over step
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      value_r <= RESET_VALUE;
    end else if (i_load) begin
      value_r <= i_seed;
    end else if (i_step) begin
      value_r <= lfsr_next(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign o_value = value_r;

endmodule

// File: rtl/bus_memtest_initiator.sv
// Memory-test bus initiator: writes an LFSR pattern over a word region, reads it back,
// and reports pass/fail with the first mismatch captured.
module bus_memtest_initiator
  import memtest_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned WORDS   = 256,
  parameter logic [31:0] SEED    = 32'h1234_5678,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [31:0] o_fail_address,
  output logic [31:0] o_fail_expected,
  output logic [31:0] o_fail_actual,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata
);

  localparam logic [31:0] LAST_INDEX   = 32'(WORDS - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state_r;
  logic [31:0] index_r;
  logic [31:0] tcnt_r;
  logic        busy_r, done_r, pass_r, timeout_r, fail_r;
  logic [31:0] fail_address_r, fail_expected_r, fail_actual_r;
  logic        bus_rw_r, bus_request_r;
  logic [31:0] bus_address_r, bus_wdata_r;

  logic        accept_s, last_s, mismatch_s, lfsr_load_s, lfsr_step_s;
  logic [31:0] address_s, lfsr_value_s;

  lfsr32 #(.RESET_VALUE(SEED)) u_lfsr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (lfsr_load_s),
    .i_seed  (SEED),
    .i_step  (lfsr_step_s),
    .o_value (lfsr_value_s)
  );

  // Handshake decode and LFSR control; LFSR re-seeds between write and read passes
  always_comb begin
    accept_s    = bus_request_r & i_bus_ready;
    last_s      = (index_r == LAST_INDEX);
    mismatch_s  = (i_bus_rdata != lfsr_value_s);
    address_s   = BASE + {index_r[29:0], 2'b00};
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        lfsr_load_s = i_start;
      end
      ST_W_REQ: begin
        lfsr_load_s = accept_s & last_s;
        lfsr_step_s = accept_s & ~last_s;
      end
      ST_R_REQ: begin
        lfsr_step_s = accept_s;
      end
      default: begin
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;
      end
    endcase
  end

  // Main sequencer: bus signals, result flags and mismatch capture
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r         <= ST_IDLE;
      index_r         <= 32'd0;
      tcnt_r          <= 32'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
      timeout_r       <= 1'b0;
      fail_r          <= 1'b0;
      fail_address_r  <= 32'd0;
      fail_expected_r <= 32'd0;
      fail_actual_r   <= 32'd0;
      bus_rw_r        <= 1'b0;
      bus_request_r   <= 1'b0;
      bus_address_r   <= 32'd0;
      bus_wdata_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_r         <= ST_W_REQ;
            index_r         <= 32'd0;
            tcnt_r          <= 32'd0;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            timeout_r       <= 1'b0;
            fail_r          <= 1'b0;
            fail_address_r  <= 32'd0;
            fail_expected_r <= 32'd0;
            fail_actual_r   <= 32'd0;
            bus_rw_r        <= 1'b1;
            bus_request_r   <= 1'b1;
            bus_address_r   <= BASE;
            bus_wdata_r     <= SEED;
          end
        end
        ST_W_REQ, ST_R_REQ: begin
          if (accept_s) begin
            bus_request_r <= 1'b0;
            tcnt_r        <= 32'd0;
            if (state_r == ST_R_REQ && mismatch_s && !fail_r) begin
              fail_r          <= 1'b1;
              fail_address_r  <= bus_address_r;
              fail_expected_r <= lfsr_value_s;
              fail_actual_r   <= i_bus_rdata;
            end
            if (!last_s) begin
              index_r <= index_r + 32'd1;
              state_r <= (state_r == ST_W_REQ) ? ST_W_GAP : ST_R_GAP;
            end else if (state_r == ST_W_REQ) begin
              index_r <= 32'd0;
              state_r <= ST_R_GAP;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= !(fail_r || mismatch_s) && !timeout_r;
            end
          end else if (tcnt_r == TIMEOUT_LAST) begin
            // Responder never answered: abandon the test
            bus_request_r <= 1'b0;
            tcnt_r        <= 32'd0;
            timeout_r     <= 1'b1;
            state_r       <= ST_DONE;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
            pass_r        <= 1'b0;
          end else begin
            tcnt_r <= tcnt_r + 32'd1;
          end
        end
        ST_W_GAP: begin
          state_r       <= ST_W_REQ;
          tcnt_r        <= 32'd0;
          bus_request_r <= 1'b1;
          bus_rw_r      <= 1'b1;
          bus_address_r <= address_s;
          bus_wdata_r   <= lfsr_value_s;
        end
        ST_R_GAP: begin
          state_r       <= ST_R_REQ;
          tcnt_r        <= 32'd0;
          bus_request_r <= 1'b1;
          bus_rw_r      <= 1'b0;
          bus_address_r <= address_s;
        end
        default: begin
          state_r       <= ST_IDLE;
          bus_request_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = busy_r;
  assign o_done          = done_r;
  assign o_pass          = pass_r;
  assign o_timeout       = timeout_r;
  assign o_fail_address  = fail_address_r;
  assign o_fail_expected = fail_expected_r;
  assign o_fail_actual   = fail_actual_r;
  assign o_bus_rw        = bus_rw_r;
  assign o_bus_request   = bus_request_r;
  assign o_bus_address   = bus_address_r;
  assign o_bus_wdata     = bus_wdata_r;

endmodule
